// File: rtl/vx_dma_bus_arb.sv
// N-to-1 round-robin arbiter for the DMA request/response bus with per-channel
// outstanding limits, a registered request stage and a sticky protocol-error flag.
module vx_dma_bus_arb #(
    parameter  int NUM_REQS      = 4,
    parameter  int ADDR_WIDTH    = 32,
    parameter  int DATA_WIDTH    = 64,
    parameter  int TAG_WIDTH     = 8,
    parameter  int MAX_PENDING   = 8,
    localparam int SEL_BITS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int OUT_TAG_WIDTH = TAG_WIDTH + SEL_BITS,
    localparam int CNT_WIDTH     = $clog2(MAX_PENDING + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQS-1:0]                  in_req_valid,
    input  logic [NUM_REQS-1:0]                  in_req_rw,
    input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  in_req_addr,
    input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  in_req_data,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   in_req_tag,
    output logic [NUM_REQS-1:0]                  in_req_ready,
    output logic [NUM_REQS-1:0]                  in_rsp_valid,
    output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  in_rsp_data,
    output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   in_rsp_tag,
    input  logic [NUM_REQS-1:0]                  in_rsp_ready,
    output logic                                 out_req_valid,
    output logic                                 out_req_rw,
    output logic [ADDR_WIDTH-1:0]                out_req_addr,
    output logic [DATA_WIDTH-1:0]                out_req_data,
    output logic [OUT_TAG_WIDTH-1:0]             out_req_tag,
    input  logic                                 out_req_ready,
    input  logic                                 out_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                out_rsp_data,
    input  logic [OUT_TAG_WIDTH-1:0]             out_rsp_tag,
    output logic                                 out_rsp_ready,
    output logic [NUM_REQS-1:0][CNT_WIDTH-1:0]   pending_count,
    output logic                                 err
);

    logic                                out_req_valid_q, out_req_valid_d;
    logic                                out_req_rw_q, out_req_rw_d;
    logic [ADDR_WIDTH-1:0]               out_req_addr_q, out_req_addr_d;
    logic [DATA_WIDTH-1:0]               out_req_data_q, out_req_data_d;
    logic [OUT_TAG_WIDTH-1:0]            out_req_tag_q, out_req_tag_d;
    logic [SEL_BITS-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [NUM_REQS-1:0][CNT_WIDTH-1:0]  pending_q, pending_d;
    logic                                err_q, err_d;

    logic [NUM_REQS-1:0] eligible;
    logic [NUM_REQS-1:0] req_inc;
    logic [NUM_REQS-1:0] rsp_dec;
    logic                grant_found;
    logic [SEL_BITS-1:0] grant_idx;
    logic [SEL_BITS:0]   cand;
    logic                stage_load;
    logic                req_fire;
    logic [SEL_BITS-1:0] rsp_sel;
    logic                rsp_ok;
    logic                rsp_chan_ready;
    logic                rsp_fire;
    logic                rsp_bad;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = in_req_valid[i] && (pending_q[i] < CNT_WIDTH'(MAX_PENDING));
        end
    end

    // Scan from rr_ptr upward with wrap; the first eligible channel wins.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = {1'b0, rr_ptr_q} + (SEL_BITS + 1)'(k);
            if (cand >= (SEL_BITS + 1)'(NUM_REQS)) begin
                cand = cand - (SEL_BITS + 1)'(NUM_REQS);
            end
            if (!grant_found && eligible[cand[SEL_BITS-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SEL_BITS-1:0];
            end
        end
    end

    assign stage_load = !out_req_valid_q || out_req_ready;
    assign req_fire   = grant_found && stage_load && !reset;

    assign rsp_sel = out_rsp_tag[OUT_TAG_WIDTH-1 -: SEL_BITS];

    // An index beyond NUM_REQS matches no channel, which makes the response bad.
    always_comb begin
        rsp_ok         = 1'b0;
        rsp_chan_ready = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rsp_sel == SEL_BITS'(i)) begin
                rsp_ok         = (pending_q[i] != '0);
                rsp_chan_ready = in_rsp_ready[i];
            end
        end
    end

    assign out_rsp_ready = !reset && (rsp_ok ? rsp_chan_ready : 1'b1);
    assign rsp_fire      = out_rsp_valid && out_rsp_ready && rsp_ok;
    assign rsp_bad       = out_rsp_valid && !rsp_ok && !reset;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            in_req_ready[i] = req_fire && (grant_idx == SEL_BITS'(i));
            in_rsp_valid[i] = !reset && out_rsp_valid && rsp_ok && (rsp_sel == SEL_BITS'(i));
            in_rsp_data[i]  = out_rsp_data;
            in_rsp_tag[i]   = out_rsp_tag[TAG_WIDTH-1:0];
            req_inc[i]      = in_req_ready[i];
            rsp_dec[i]      = rsp_fire && (rsp_sel == SEL_BITS'(i));
        end
    end

    always_comb begin
        out_req_valid_d = out_req_valid_q;
        out_req_rw_d    = out_req_rw_q;
        out_req_addr_d  = out_req_addr_q;
        out_req_data_d  = out_req_data_q;
        out_req_tag_d   = out_req_tag_q;
        rr_ptr_d        = rr_ptr_q;
        pending_d       = pending_q;
        err_d           = err_q || rsp_bad;

        if (req_fire) begin
            out_req_valid_d = 1'b1;
            out_req_rw_d    = in_req_rw[grant_idx];
            out_req_addr_d  = in_req_addr[grant_idx];
            out_req_data_d  = in_req_data[grant_idx];
            out_req_tag_d   = {grant_idx, in_req_tag[grant_idx]};
            rr_ptr_d        = (grant_idx == SEL_BITS'(NUM_REQS - 1)) ? '0
                                                                       : grant_idx + SEL_BITS'(1);
        end else if (out_req_ready) begin
            out_req_valid_d = 1'b0;
        end

        // A same-cycle issue and retire on one channel leaves its count untouched.
        for (int i = 0; i < NUM_REQS; i++) begin
            if (req_inc[i] && !rsp_dec[i]) begin
                pending_d[i] = pending_q[i] + CNT_WIDTH'(1);
            end else if (!req_inc[i] && rsp_dec[i]) begin
                pending_d[i] = pending_q[i] - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_req_valid_q <= 1'b0;
            out_req_rw_q    <= 1'b0;
            out_req_addr_q  <= '0;
            out_req_data_q  <= '0;
            out_req_tag_q   <= '0;
            rr_ptr_q        <= '0;
            pending_q       <= '0;
            err_q           <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            out_req_valid_q <= out_req_valid_d;
            out_req_rw_q    <= out_req_rw_d;
            out_req_addr_q  <= out_req_addr_d;
            out_req_data_q  <= out_req_data_d;
            out_req_tag_q   <= out_req_tag_d;
            rr_ptr_q        <= rr_ptr_d;
            pending_q       <= pending_d;
            err_q           <= err_d;
        end
    end

    assign out_req_valid = out_req_valid_q;
    assign out_req_rw    = out_req_rw_q;
    assign out_req_addr  = out_req_addr_q;
    assign out_req_data  = out_req_data_q;
    assign out_req_tag   = out_req_tag_q;
    assign pending_count = pending_q;
    assign err           = err_q;

endmodule

// File: tb/tb_vx_dma_bus_arb.sv
// Bench for vx_dma_bus_arb: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration and routing rules.
module tb_vx_dma_bus_arb;

    localparam int N   = 4;
    localparam int N3  = 3;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int TW  = 8;
    localparam int MP  = 2;
    localparam int SB  = 2;
    localparam int OTW = TW + SB;
    localparam int CW  = 2;

    typedef struct packed {
        logic          v;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [OTW-1:0] tag;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [N-1:0]              in_req_valid, in_req_rw, in_req_ready;
    logic [N-1:0][AW-1:0]      in_req_addr;
    logic [N-1:0][DW-1:0]      in_req_data;
    logic [N-1:0][TW-1:0]      in_req_tag;
    logic [N-1:0]              in_rsp_valid, in_rsp_ready;
    logic [N-1:0][DW-1:0]      in_rsp_data;
    logic [N-1:0][TW-1:0]      in_rsp_tag;
    logic                      out_req_valid, out_req_rw, out_req_ready;
    logic [AW-1:0]             out_req_addr;
    logic [DW-1:0]             out_req_data;
    logic [OTW-1:0]            out_req_tag;
    logic                      out_rsp_valid, out_rsp_ready;
    logic [DW-1:0]             out_rsp_data;
    logic [OTW-1:0]            out_rsp_tag;
    logic [N-1:0][CW-1:0]      pending_count;
    logic                      err;

    // 3-channel instance (index field can hold an out-of-range value)
    logic [N3-1:0]             in_req_valid3, in_req_rw3, in_req_ready3;
    logic [N3-1:0][AW-1:0]     in_req_addr3;
    logic [N3-1:0][DW-1:0]     in_req_data3;
    logic [N3-1:0][TW-1:0]     in_req_tag3;
    logic [N3-1:0]             in_rsp_valid3, in_rsp_ready3;
    logic [N3-1:0][DW-1:0]     in_rsp_data3;
    logic [N3-1:0][TW-1:0]     in_rsp_tag3;
    logic                      out_req_valid3, out_req_rw3, out_req_ready3;
    logic [AW-1:0]             out_req_addr3;
    logic [DW-1:0]             out_req_data3;
    logic [OTW-1:0]            out_req_tag3;
    logic                      out_rsp_valid3, out_rsp_ready3;
    logic [DW-1:0]             out_rsp_data3;
    logic [OTW-1:0]            out_rsp_tag3;
    logic [N3-1:0][CW-1:0]     pending_count3;
    logic                      err3;

    int n_checks = 0;
    int n_pass   = 0;

    vx_dma_bus_arb #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
        .in_req_data(in_req_data), .in_req_tag(in_req_tag), .in_req_ready(in_req_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .in_rsp_ready(in_rsp_ready),
        .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
        .out_req_data(out_req_data), .out_req_tag(out_req_tag), .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
        .out_rsp_ready(out_rsp_ready), .pending_count(pending_count), .err(err)
    );

    vx_dma_bus_arb #(.NUM_REQS(N3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut3 (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid3), .in_req_rw(in_req_rw3), .in_req_addr(in_req_addr3),
        .in_req_data(in_req_data3), .in_req_tag(in_req_tag3), .in_req_ready(in_req_ready3),
        .in_rsp_valid(in_rsp_valid3), .in_rsp_data(in_rsp_data3), .in_rsp_tag(in_rsp_tag3),
        .in_rsp_ready(in_rsp_ready3),
        .out_req_valid(out_req_valid3), .out_req_rw(out_req_rw3), .out_req_addr(out_req_addr3),
        .out_req_data(out_req_data3), .out_req_tag(out_req_tag3), .out_req_ready(out_req_ready3),
        .out_rsp_valid(out_rsp_valid3), .out_rsp_data(out_rsp_data3), .out_rsp_tag(out_rsp_tag3),
        .out_rsp_ready(out_rsp_ready3), .pending_count(pending_count3), .err(err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_req_valid = '0; in_req_rw = '0; in_req_addr = '0; in_req_data = '0; in_req_tag = '0;
        in_rsp_ready = '0; out_req_ready = 1'b0; out_rsp_valid = 1'b0; out_rsp_data = '0; out_rsp_tag = '0;
        in_req_valid3 = '0; in_req_rw3 = '0; in_req_addr3 = '0; in_req_data3 = '0; in_req_tag3 = '0;
        in_rsp_ready3 = '0; out_req_ready3 = 1'b0; out_rsp_valid3 = 1'b0; out_rsp_data3 = '0; out_rsp_tag3 = '0;
    endtask

    // Called one time unit after a rising edge; reset pulses well clear of the next edge.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic set_channel_fields();
        for (int i = 0; i < N; i++) begin
            in_req_tag[i]  = 8'(8'h10 + i);
            in_req_addr[i] = 16'(16'hA000 + i);
            in_req_data[i] = 32'(32'hD000_0000 + i);
            in_req_rw[i]   = 1'(i % 2);
        end
    endtask

    task automatic test_reset();
        in_req_valid  = 4'hF;
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {2'd1, 8'h00};
        in_rsp_ready  = 4'hF;
        out_req_ready = 1'b1;
        tick();
        n_checks++; if (in_req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", in_req_ready); else n_pass++;
        n_checks++; if (in_rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", in_rsp_valid); else n_pass++;
        n_checks++; if (out_rsp_ready !== 1'b0) $display("FAIL reset_out_rsp_ready: got %b want 0", out_rsp_ready); else n_pass++;
        n_checks++; if (out_req_valid !== 1'b0) $display("FAIL reset_out_req_valid: got %b want 0", out_req_valid); else n_pass++;
        n_checks++; if (pending_count !== '0) $display("FAIL reset_pending: got %h want 0", pending_count); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [OTW-1:0] exp_tag;
        int e;
        do_reset();
        set_channel_fields();
        in_req_valid  = 4'hF;
        out_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = k % N;
            #1;
            n_checks++; if (in_req_ready !== 4'(1 << e)) $display("FAIL rr_grant%0d: got %b want %b", k, in_req_ready, 4'(1 << e)); else n_pass++;
            tick();
            exp_tag = {2'(e), 8'(8'h10 + e)};
            n_checks++; if (out_req_valid !== 1'b1 || out_req_tag !== exp_tag || out_req_addr !== 16'(16'hA000 + e))
                $display("FAIL rr_out%0d: got v=%b tag=%h addr=%h want v=1 tag=%h addr=%h", k, out_req_valid, out_req_tag, out_req_addr, exp_tag, 16'(16'hA000 + e));
            else n_pass++;
        end
        n_checks++; if (pending_count !== {2'd1, 2'd1, 2'd1, 2'd2}) $display("FAIL rr_pending: got %h want %h", pending_count, {2'd1, 2'd1, 2'd1, 2'd2}); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_channel_fields();
        in_req_valid  = 4'b0100;
        out_req_ready = 1'b0;
        #1;
        n_checks++; if (in_req_ready !== 4'b0100) $display("FAIL bp_first_grant: got %b want 0100", in_req_ready); else n_pass++;
        tick();
        in_req_valid = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (in_req_ready !== 4'b0000) $display("FAIL bp_ready%0d: got %b want 0000", k, in_req_ready); else n_pass++;
            n_checks++; if (out_req_valid !== 1'b1 || out_req_tag !== {2'd2, 8'h12} || out_req_addr !== 16'hA002 || out_req_data !== 32'hD000_0002)
                $display("FAIL bp_hold%0d: got v=%b tag=%h addr=%h want v=1 tag=212 addr=a002", k, out_req_valid, out_req_tag, out_req_addr);
            else n_pass++;
            tick();
        end
        out_req_ready = 1'b1;
        #1;
        n_checks++; if (in_req_ready !== 4'b1000) $display("FAIL bp_drain_grant: got %b want 1000", in_req_ready); else n_pass++;
        tick();
        n_checks++; if (out_req_tag !== {2'd3, 8'h13}) $display("FAIL bp_next_tag: got %h want %h", out_req_tag, {2'd3, 8'h13}); else n_pass++;
    endtask

    task automatic test_pending_limit();
        do_reset();
        in_req_valid  = 4'b0010;
        in_req_tag[1] = 8'h05;
        out_req_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (in_req_ready !== 4'b0010) $display("FAIL lim_grant%0d: got %b want 0010", k, in_req_ready); else n_pass++;
            tick();
        end
        #1;
        n_checks++; if (in_req_ready !== 4'b0000) $display("FAIL lim_blocked: got %b want 0000", in_req_ready); else n_pass++;
        tick();
        n_checks++; if (pending_count[1] !== 2'd2) $display("FAIL lim_count: got %0d want 2", pending_count[1]); else n_pass++;
        n_checks++; if (out_req_valid !== 1'b0) $display("FAIL lim_stage_empty: got %b want 0", out_req_valid); else n_pass++;
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {2'd1, 8'h05};
        out_rsp_data  = 32'hCAFE_0001;
        in_rsp_ready  = 4'b0010;
        #1;
        n_checks++; if (in_rsp_valid !== 4'b0010) $display("FAIL lim_rsp_valid: got %b want 0010", in_rsp_valid); else n_pass++;
        n_checks++; if (in_rsp_tag[1] !== 8'h05 || in_rsp_data[1] !== 32'hCAFE_0001)
            $display("FAIL lim_rsp_fields: got tag=%h data=%h want 05 cafe0001", in_rsp_tag[1], in_rsp_data[1]); else n_pass++;
        n_checks++; if (out_rsp_ready !== 1'b1) $display("FAIL lim_out_rsp_ready: got %b want 1", out_rsp_ready); else n_pass++;
        tick();
        out_rsp_valid = 1'b0;
        n_checks++; if (pending_count[1] !== 2'd1) $display("FAIL lim_after_rsp: got %0d want 1", pending_count[1]); else n_pass++;
        #1;
        n_checks++; if (in_req_ready !== 4'b0010) $display("FAIL lim_regrant: got %b want 0010", in_req_ready); else n_pass++;
        tick();
        n_checks++; if (pending_count[1] !== 2'd2) $display("FAIL lim_refill: got %0d want 2", pending_count[1]); else n_pass++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        in_req_valid  = 4'b0001;
        in_req_tag[0] = 8'h33;
        out_req_ready = 1'b1;
        tick();
        n_checks++; if (pending_count[0] !== 2'd1) $display("FAIL sc_first: got %0d want 1", pending_count[0]); else n_pass++;
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {2'd0, 8'h33};
        in_rsp_ready  = 4'b0001;
        #1;
        n_checks++; if (in_req_ready !== 4'b0001 || out_rsp_ready !== 1'b1 || in_rsp_valid !== 4'b0001)
            $display("FAIL sc_both_fire: got req_rdy=%b rsp_rdy=%b rsp_v=%b want 0001 1 0001", in_req_ready, out_rsp_ready, in_rsp_valid);
        else n_pass++;
        tick();
        n_checks++; if (pending_count[0] !== 2'd1) $display("FAIL sc_unchanged: got %0d want 1", pending_count[0]); else n_pass++;
        in_req_valid = 4'b0000;
        tick();
        out_rsp_valid = 1'b0;
        n_checks++; if (pending_count[0] !== 2'd0) $display("FAIL sc_retire: got %0d want 0", pending_count[0]); else n_pass++;
    endtask

    task automatic test_bad_rsp();
        do_reset();
        out_rsp_valid3 = 1'b1;
        out_rsp_tag3   = {2'd3, 8'hAA};
        in_rsp_ready3  = 3'b000;
        #1;
        n_checks++; if (out_rsp_ready3 !== 1'b1) $display("FAIL bad_oor_ready: got %b want 1", out_rsp_ready3); else n_pass++;
        n_checks++; if (in_rsp_valid3 !== 3'b000) $display("FAIL bad_oor_valid: got %b want 000", in_rsp_valid3); else n_pass++;
        n_checks++; if (err3 !== 1'b0) $display("FAIL bad_oor_err_early: got %b want 0", err3); else n_pass++;
        tick();
        out_rsp_valid3 = 1'b0;
        n_checks++; if (err3 !== 1'b1) $display("FAIL bad_oor_err: got %b want 1", err3); else n_pass++;
        do_reset();
        out_rsp_valid3 = 1'b1;
        out_rsp_tag3   = {2'd1, 8'h01};
        in_rsp_ready3  = 3'b000;
        #1;
        n_checks++; if (out_rsp_ready3 !== 1'b1 || in_rsp_valid3 !== 3'b000)
            $display("FAIL bad_zero_route: got ready=%b valid=%b want 1 000", out_rsp_ready3, in_rsp_valid3); else n_pass++;
        tick();
        out_rsp_valid3 = 1'b0;
        tick();
        tick();
        n_checks++; if (err3 !== 1'b1) $display("FAIL bad_zero_sticky: got %b want 1", err3); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_channel_fields();
        in_req_valid  = 4'b0111;
        out_req_ready = 1'b1;
        tick();
        tick();
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {2'd3, 8'h00};
        tick();
        out_rsp_valid = 1'b0;
        out_req_ready = 1'b0;
        in_req_valid  = 4'hF;
        n_checks++; if (pending_count !== {2'd0, 2'd1, 2'd1, 2'd1} || err !== 1'b1 || out_req_valid !== 1'b1)
            $display("FAIL mid_before: got pend=%h err=%b v=%b want 15 1 1", pending_count, err, out_req_valid); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (pending_count !== '0) $display("FAIL mid_pending: got %h want 0", pending_count); else n_pass++;
        n_checks++; if (out_req_valid !== 1'b0 || err !== 1'b0) $display("FAIL mid_state: got v=%b err=%b want 0 0", out_req_valid, err); else n_pass++;
        n_checks++; if (in_req_ready !== 4'b0000) $display("FAIL mid_ready_in_reset: got %b want 0000", in_req_ready); else n_pass++;
        #1;
        reset = 1'b0;
        out_req_ready = 1'b1;
        #1;
        n_checks++; if (in_req_ready !== 4'b0001) $display("FAIL mid_next_grant: got %b want 0001", in_req_ready); else n_pass++;
        tick();
        n_checks++; if (out_req_tag[OTW-1 -: SB] !== 2'd0) $display("FAIL mid_next_tag: got %0d want 0", out_req_tag[OTW-1 -: SB]); else n_pass++;
    endtask

    // Transaction-level model: issue grants from a pointer and per-channel
    // outstanding counters, retire them on routed responses.
    task automatic test_random();
        req_t m_st;
        int   m_rr;
        int   m_pend[N];
        do_reset();
        m_st = '0;
        m_rr = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic       rdy, rsp_on, can_load, exp_orr;
            logic [3:0] exp_rdy, exp_rv;
            logic [TW-1:0] rtag;
            int         win, rc;
            for (int i = 0; i < N; i++) begin
                in_req_tag[i]  = 8'($urandom);
                in_req_addr[i] = 16'($urandom);
                in_req_data[i] = $urandom;
                in_req_rw[i]   = 1'($urandom);
            end
            in_req_valid  = 4'($urandom);
            rdy           = ($urandom_range(0, 3) != 0);
            out_req_ready = rdy;
            rc            = $urandom_range(0, N - 1);
            rsp_on        = ($urandom_range(0, 1) == 1) && (m_pend[rc] > 0);
            rtag          = 8'($urandom);
            out_rsp_valid = rsp_on;
            out_rsp_tag   = {2'(rc), rtag};
            out_rsp_data  = $urandom;
            in_rsp_ready  = 4'($urandom);

            can_load = !m_st.v || rdy;
            win = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (win < 0 && in_req_valid[c] && m_pend[c] < MP) win = c;
            end
            exp_rdy = (win >= 0 && can_load) ? 4'(1 << win) : 4'b0000;
            exp_rv  = rsp_on ? 4'(1 << rc) : 4'b0000;
            exp_orr = (m_pend[rc] > 0) ? in_rsp_ready[rc] : 1'b1;
            #1;
            n_checks++; if (in_req_ready !== exp_rdy) $display("FAIL rnd_req_ready c%0d: got %b want %b", cyc, in_req_ready, exp_rdy); else n_pass++;
            n_checks++; if (in_rsp_valid !== exp_rv) $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, in_rsp_valid, exp_rv); else n_pass++;
            n_checks++; if (out_rsp_ready !== exp_orr) $display("FAIL rnd_out_rsp_ready c%0d: got %b want %b", cyc, out_rsp_ready, exp_orr); else n_pass++;
            if (rsp_on) begin
                n_checks++; if (in_rsp_tag[rc] !== rtag) $display("FAIL rnd_rsp_tag c%0d: got %h want %h", cyc, in_rsp_tag[rc], rtag); else n_pass++;
            end
            @(posedge clk);
            #1;
            if (exp_rdy != 4'b0000) begin
                m_st = '{v: 1'b1, rw: in_req_rw[win], addr: in_req_addr[win], data: in_req_data[win],
                         tag: {2'(win), in_req_tag[win]}};
                m_rr = (win + 1) % N;
                m_pend[win]++;
            end else if (rdy) begin
                m_st.v = 1'b0;
            end
            if (rsp_on && in_rsp_ready[rc]) m_pend[rc]--;
            n_checks++; if (out_req_valid !== m_st.v) $display("FAIL rnd_out_valid c%0d: got %b want %b", cyc, out_req_valid, m_st.v); else n_pass++;
            if (m_st.v) begin
                n_checks++; if ({out_req_rw, out_req_addr, out_req_data, out_req_tag} !== {m_st.rw, m_st.addr, m_st.data, m_st.tag})
                    $display("FAIL rnd_out_fields c%0d: got tag=%h addr=%h want tag=%h addr=%h", cyc, out_req_tag, out_req_addr, m_st.tag, m_st.addr);
                else n_pass++;
            end
            for (int i = 0; i < N; i++) begin
                n_checks++; if (pending_count[i] !== CW'(m_pend[i])) $display("FAIL rnd_pending%0d c%0d: got %0d want %0d", i, cyc, pending_count[i], m_pend[i]); else n_pass++;
            end
        end
        n_checks++; if (err !== 1'b0) $display("FAIL rnd_err: got %b want 0", err); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        #1;
        reset = 1'b1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_pending_limit();
        test_same_cycle();
        test_bad_rsp();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
